// File: rtl/ps2_text_cursor.sv
// PS/2 scan-code to text-screen cursor controller: pops bytes from the
// keyboard FIFO, decodes make/break/extended codes and drives video-memory
// writes of raw scan codes plus an upper-case flag.
//
// Ports:
//   clk, reset (sync, active-high)
//   data/ready/overflow in, nextdata_n out : ps2_keyboard FIFO side
//   vm_we/vm_addr/vm_data/vm_upper         : video-memory write port
//   cur_row/cur_col, upper, key_down,
//   last_code, ovf_sticky                  : status
module ps2_text_cursor #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data,
  input  logic              ready,
  input  logic              overflow,
  output logic              nextdata_n,
  output logic              vm_we,
  output logic [ADDR_W-1:0] vm_addr,
  output logic [7:0]        vm_data,
  output logic              vm_upper,
  output logic [RW-1:0]     cur_row,
  output logic [CW-1:0]     cur_col,
  output logic              upper,
  output logic              key_down,
  output logic [7:0]        last_code,
  output logic              ovf_sticky
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    GAP
  } state_t;

  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wup_q, wup_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              caps_q, caps_d;
  logic              shl_q, shl_d;
  logic              shr_q, shr_d;
  logic              held_q, held_d;
  logic              brk_q, brk_d;
  logic              ext_q, ext_d;
  logic              kd_q, kd_d;
  logic [7:0]        last_q, last_d;
  logic              ovf_q, ovf_d;
  logic              accept;
  logic              up_w;
  logic              is_mod;

  function automatic logic [ADDR_W-1:0] pos(
    input logic [RW-1:0] r,
    input logic [CW-1:0] c
  );
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  assign up_w   = caps_q ^ (shl_q | shr_q);
  assign is_mod = (data == 8'h12) || (data == 8'h59) ||
                  (data == 8'h58);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ready) begin
          state_d = ACK;
          accept  = 1'b1;
        end
      end
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wup_d   = wup_q;
    row_d   = row_q;
    col_d   = col_q;
    caps_d  = caps_q;
    shl_d   = shl_q;
    shr_d   = shr_q;
    held_d  = held_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    kd_d    = kd_q;
    last_d  = last_q;
    ovf_d   = ovf_q | overflow;
    if (accept) begin
      if (data == 8'hF0) begin
        brk_d = 1'b1;
      end else if (data == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (brk_q) begin
          // Extended breaks of modifier codes are not modifiers.
          if (!is_mod) begin
            kd_d = 1'b0;
          end else if (!ext_q) begin
            case (data)
              8'h12:   shl_d  = 1'b0;
              8'h59:   shr_d  = 1'b0;
              default: held_d = 1'b0;
            endcase
          end
        end else begin
          last_d = data;
          if (ext_q) begin
            case (data)
              8'h6B: if (col_q != '0) col_d = col_q - 1'b1;
              8'h74: if (col_q != COL_MAX) col_d = col_q + 1'b1;
              8'h75: if (row_q != '0) row_d = row_q - 1'b1;
              8'h72: if (row_q != ROW_MAX) row_d = row_q + 1'b1;
              default: ;
            endcase
          end else begin
            case (data)
              8'h12: shl_d = 1'b1;
              8'h59: shr_d = 1'b1;
              8'h58: begin
                // Typematic repeats of Caps must not re-toggle.
                if (!held_q) caps_d = ~caps_q;
                held_d = 1'b1;
              end
              8'h66: begin
                if (col_q != '0) begin
                  col_d = col_q - 1'b1;
                end else if (row_q != '0) begin
                  row_d = row_q - 1'b1;
                  col_d = COL_MAX;
                end
                we_d    = 1'b1;
                addr_d  = pos(row_d, col_d);
                wdata_d = 8'h00;
                wup_d   = 1'b0;
              end
              8'h5A: begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
              end
              default: begin
                we_d    = 1'b1;
                addr_d  = pos(row_q, col_q);
                wdata_d = data;
                wup_d   = up_w;
                kd_d    = 1'b1;
                if (col_q != COL_MAX) begin
                  col_d = col_q + 1'b1;
                end else begin
                  col_d = '0;
                  row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
                end
              end
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wup_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      caps_q  <= 1'b0;
      shl_q   <= 1'b0;
      shr_q   <= 1'b0;
      held_q  <= 1'b0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      kd_q    <= 1'b0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wup_q   <= wup_d;
      row_q   <= row_d;
      col_q   <= col_d;
      caps_q  <= caps_d;
      shl_q   <= shl_d;
      shr_q   <= shr_d;
      held_q  <= held_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      kd_q    <= kd_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign nextdata_n = (state_q != ACK);
  assign vm_we      = we_q;
  assign vm_addr    = addr_q;
  assign vm_data    = wdata_q;
  assign vm_upper   = wup_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign upper      = up_w;
  assign key_down   = kd_q;
  assign last_code  = last_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ps2_text_cursor.sv
// Scoreboard bench for ps2_text_cursor: directed scan-code sequences,
// expected writes queued at issue time and checked by a monitor.
module tb_ps2_text_cursor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        ready = 1'b0;
  logic        overflow = 1'b0;
  logic        nextdata_n;
  logic        vm_we;
  logic [11:0] vm_addr;
  logic [7:0]  vm_data;
  logic        vm_upper;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        upper;
  logic        key_down;
  logic [7:0]  last_code;
  logic        ovf_sticky;

  ps2_text_cursor #(.COLS(70), .ROWS(30), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .data(data), .ready(ready),
    .overflow(overflow), .nextdata_n(nextdata_n), .vm_we(vm_we),
    .vm_addr(vm_addr), .vm_data(vm_data), .vm_upper(vm_upper),
    .cur_row(cur_row), .cur_col(cur_col), .upper(upper),
    .key_down(key_down), .last_code(last_code),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
    logic        u;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  pops = 0;
  bit  prev_we = 1'b0;
  bit  prev_nd = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (vm_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none",
                 vm_addr, vm_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", vm_addr, e.a);
        chk("wr_data", vm_data, e.d);
        chk("wr_upper", vm_upper, e.u);
      end
      chk("we_width", prev_we, 0);
    end
    if (!nextdata_n) begin
      pops++;
      chk("nd_width", prev_nd, 0);
    end
    prev_we = vm_we;
    prev_nd = !nextdata_n;
  end

  task automatic expw(input int a, input logic [7:0] d, input logic u);
    wr_t e;
    e.a = a[11:0];
    e.d = d;
    e.u = u;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    @(negedge clk);
    data  = b;
    ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (nextdata_n && n < 10);
    if (n >= 10) begin
      tests++;
      fails++;
      $display("FAIL pop_timeout: got no pop expected pop of %0h", b);
    end
    ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pops = 0;
  endtask

  task automatic chk_cur(input string nm, input int r, input int c);
    chk({nm, "_row"}, cur_row, r);
    chk({nm, "_col"}, cur_col, c);
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_nd"}, nextdata_n, 1);
    chk({nm, "_we"}, vm_we, 0);
    chk({nm, "_addr"}, vm_addr, 0);
    chk({nm, "_data"}, vm_data, 0);
    chk({nm, "_vup"}, vm_upper, 0);
    chk_cur(nm, 0, 0);
    chk({nm, "_upper"}, upper, 0);
    chk({nm, "_kd"}, key_down, 0);
    chk({nm, "_last"}, last_code, 0);
    chk({nm, "_ovf"}, ovf_sticky, 0);
  endtask

  logic [7:0] codes [4] = '{8'h15, 8'h1D, 8'h24, 8'h2D};

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_rst("rst0");

    // Single key make/break.
    do_reset();
    expw(0, 8'h1C, 1'b0);
    push(8'h1C);
    chk("t1_kd_make", key_down, 1);
    push(8'hF0);
    push(8'h1C);
    repeat (3) @(negedge clk);
    chk("t1_pops", pops, 3);
    chk_cur("t1", 0, 1);
    chk("t1_kd_brk", key_down, 0);
    chk("t1_last", last_code, 8'h1C);

    // Caps toggle with typematic repeat.
    do_reset();
    push(8'h58);
    push(8'h58);
    chk("t2_up_rep", upper, 1);
    push(8'hF0);
    push(8'h58);
    expw(0, 8'h1C, 1'b1);
    push(8'h1C);
    chk("t2_up_after", upper, 1);
    push(8'h58);
    push(8'h58);
    chk("t2_up_off", upper, 0);

    // Shift held then released.
    do_reset();
    push(8'h12);
    chk("t3_up_sh", upper, 1);
    expw(0, 8'h1C, 1'b1);
    push(8'h1C);
    push(8'hF0);
    push(8'h12);
    chk("t3_up_rel", upper, 0);
    expw(1, 8'h1C, 1'b0);
    push(8'h1C);

    // Row wrap and Backspace across a row boundary.
    do_reset();
    for (int i = 0; i < 70; i++) begin
      expw(i, codes[i % 4], 1'b0);
      push(codes[i % 4]);
    end
    chk_cur("t4_wrap", 1, 0);
    expw(69, 8'h00, 1'b0);
    push(8'h66);
    chk_cur("t4_bs", 0, 69);
    do_reset();
    expw(0, 8'h00, 1'b0);
    push(8'h66);
    chk_cur("t4_bs00", 0, 0);

    // Extended arrows with saturation, then Enter.
    do_reset();
    push(8'hE0);
    push(8'h6B);
    push(8'hE0);
    push(8'h75);
    chk_cur("t5_sat", 0, 0);
    for (int i = 0; i < 3; i++) begin
      push(8'hE0);
      push(8'h74);
    end
    chk_cur("t5_right", 0, 3);
    push(8'h5A);
    chk_cur("t5_enter", 1, 0);
    chk("t5_last", last_code, 8'h5A);

    // Overflow sticky, then reset during ACK.
    do_reset();
    @(negedge clk);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    expw(0, 8'h1C, 1'b0);
    push(8'h1C);
    repeat (2) @(negedge clk);
    chk("t6_ovf", ovf_sticky, 1);
    expw(1, 8'h32, 1'b0);
    @(negedge clk);
    data  = 8'h32;
    ready = 1'b1;
    for (int n = 0; n < 10 && nextdata_n; n++) @(negedge clk);
    chk("t6_in_ack", nextdata_n, 0);
    reset = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    chk_rst("t6_rst");
    reset = 1'b0;

    repeat (4) @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
